bc_polinomio: RTL

Control block (FSM) that sequences the polynomial datapath.
- Drives the datapath's mux selects (m0, m1, m2), register loads (lx, lh, ls) and ULA operation (h).
- Evaluates y = A·X² + B·X + C (grau 2) or y = B·X + C (grau 1) by Horner's rule.
- Sits beside the datapath as its control block; exposes a start/busy/done handshake to the surrounding logic.

---
 rtl/bc_polinomio.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bc_polinomio.sv
// bc_polinomio: control FSM sequencing the polynomial datapath
// y = A*X^2 + B*X + C (grau 2) or y = B*X + C (grau 1), Horner's rule.
// Ports: clk, rst (async active-low), start, mode (1 = grau 2);
//   m0/m1/m2 mux selects, lx/lh/ls register loads, h (0 add, 1 mul),
//   busy (LOAD..S4), done (one-cycle pulse).
// Option: BC_MUL_WAIT_EN holds S1/S3 for MUL_CYCLES cycles each.
module bc_polinomio #(
    parameter int MUL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       lh,
    output logic       ls,
    output logic       h,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        S4   = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t state, state_n;
    logic   grau2;
    logic   hold;
    logic   last;

`ifdef BC_MUL_WAIT_EN
    logic [3:0] cnt;

    // Multiply states stay put until the counter reaches its final count.
    assign last = (cnt == 4'(MUL_CYCLES - 1));
    assign hold = ((state == S1) || (state == S3)) && !last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state_n != state)
            cnt <= '0;
        else if (hold)
            cnt <= cnt + 4'd1;
    end
`else
    assign last = 1'b1;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grau2 <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start)
                grau2 <= mode;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = grau2 ? S1 : S3;
            S1:      if (!hold) state_n = S2;
            S2:      state_n = S3;
            S3:      if (!hold) state_n = S4;
            S4:      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        m0   = 2'd0;
        m1   = 2'd0;
        m2   = 2'd0;
        lx   = 1'b0;
        lh   = 1'b0;
        ls   = 1'b0;
        h    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            LOAD: begin
                lx   = 1'b1;
                busy = 1'b1;
            end
            S1: begin
                m0   = 2'd1;
                m1   = 2'd2;
                h    = 1'b1;
                lh   = last;
                busy = 1'b1;
            end
            S2: begin
                m0   = 2'd2;
                m1   = 2'd1;
                lh   = 1'b1;
                busy = 1'b1;
            end
            S3: begin
                // grau 2: H <- X*H ; grau 1: H <- B*X
                m0   = grau2 ? 2'd0 : 2'd2;
                m1   = grau2 ? 2'd1 : 2'd2;
                h    = 1'b1;
                lh   = last;
                busy = 1'b1;
            end
            S4: begin
                m0   = 2'd3;
                m1   = 2'd1;
                ls   = 1'b1;
                busy = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
